// File: rtl/mode_sequencer.sv
// Operating-mode sequencer: advances the mode on button edges, aligned to POP cycle boundaries.
// Optional laser-tuning override is compiled in with `define LASER_TUNING_EN.
module mode_sequencer #(
  parameter int NUM_STATES    = 7,
  parameter int CYCLE_TIMEOUT = 50000
) (
  input  logic       clk_2M5,
  input  logic       rst_n,
  input  logic       mode_button,
  input  logic       laser_tuning,
  input  logic       cycle_start,
  output logic [2:0] state,
  output logic       mode_change,
  output logic       tuning_ack
);

  localparam int CW = $clog2(CYCLE_TIMEOUT + 1);
  localparam logic [2:0] LAST = 3'(NUM_STATES - 1);
  localparam logic [CW-1:0] CNT_END = CW'(CYCLE_TIMEOUT - 1);

`ifdef LASER_TUNING_EN
  typedef enum logic [1:0] {
    RUN, WAIT, TUNE_WAIT, TUNE
  } ctl_e;
`else
  typedef enum logic [1:0] {
    RUN, WAIT
  } ctl_e;
`endif

  ctl_e          ctl_q, ctl_d;
  logic [2:0]    state_q, state_d;
  logic          chg_q, chg_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q;

  logic       btn_edge;
  logic [2:0] nxt;
  logic       pop;
  logic       boundary;

`ifdef LASER_TUNING_EN
  logic       ack_q, ack_d;
  logic [2:0] saved_q, saved_d;
  logic       tune_s1_q, tune_s2_q, tune_q;
  logic       tune_rise, tune_fall;

  assign tune_rise = tune_s2_q & ~tune_q;
  assign tune_fall = ~tune_s2_q & tune_q;
`else
  logic unused_tune;
  assign unused_tune = laser_tuning;
`endif

  assign btn_edge = mode_button & ~btn_q;
  assign nxt      = (state_q == LAST) ? 3'd0 : state_q + 3'd1;
  // Modes 1 and 6 drive POP cycles, so they may only change on a boundary
  assign pop      = (state_q == 3'd1) || (state_q == 3'd6);
  assign boundary = cycle_start || (cnt_q == CNT_END);

  always_comb begin
    ctl_d   = ctl_q;
    state_d = state_q;
    chg_d   = 1'b0;
    pend_d  = pend_q | btn_edge;
    cnt_d   = cnt_q;
`ifdef LASER_TUNING_EN
    ack_d   = ack_q;
    saved_d = saved_q;
`endif
    unique case (ctl_q)
      RUN: begin
        if (pend_q) begin
          if (!pop) begin
            state_d = nxt;
            chg_d   = (nxt != state_q);
            pend_d  = 1'b0;
          end else begin
            ctl_d = WAIT;
            cnt_d = '0;
          end
        end
      end
      WAIT: begin
        if (boundary) begin
          state_d = nxt;
          chg_d   = (nxt != state_q);
          pend_d  = 1'b0;
          ctl_d   = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef LASER_TUNING_EN
      TUNE_WAIT: begin
        pend_d = 1'b0;
        if (tune_fall) begin
          ctl_d = RUN;
        end else if (!pop || boundary) begin
          state_d = 3'd0;
          chg_d   = (state_q != 3'd0);
          ack_d   = 1'b1;
          ctl_d   = TUNE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TUNE: begin
        pend_d = 1'b0;
        if (tune_fall) begin
          state_d = saved_q;
          chg_d   = (saved_q != state_q);
          ack_d   = 1'b0;
          ctl_d   = RUN;
        end
      end
`endif
      default: ctl_d = RUN;
    endcase
`ifdef LASER_TUNING_EN
    // Tuning request overrides any button commit in the same cycle
    if (tune_rise && (ctl_q == RUN || ctl_q == WAIT)) begin
      saved_d = state_q;
      state_d = state_q;
      chg_d   = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = '0;
      ctl_d   = TUNE_WAIT;
    end
`endif
  end

  always_ff @(posedge clk_2M5 or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q   <= RUN;
      state_q <= 3'd0;
      chg_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
    end else begin
      ctl_q   <= ctl_d;
      state_q <= state_d;
      chg_q   <= chg_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      btn_q   <= mode_button;
    end
  end

`ifdef LASER_TUNING_EN
  always_ff @(posedge clk_2M5 or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      saved_q   <= 3'd0;
      tune_s1_q <= 1'b0;
      tune_s2_q <= 1'b0;
      tune_q    <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      saved_q   <= saved_d;
      tune_s1_q <= laser_tuning;
      tune_s2_q <= tune_s1_q;
      tune_q    <= tune_s2_q;
    end
  end

  assign tuning_ack = ack_q;
`else
  assign tuning_ack = 1'b0;
`endif

  assign state       = state_q;
  assign mode_change = chg_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with an expected-mode scoreboard.
// Exercises the laser-tuning override when LASER_TUNING_EN is defined.
module tb_mode_sequencer;

  localparam int NS = 7;
  localparam int TO = 50000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_button = 1'b0;
  logic       laser_tuning = 1'b0;
  logic       cycle_start = 1'b0;
  logic [2:0] state;
  logic       mode_change;
  logic       tuning_ack;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cyc;
  int cnt;

  mode_sequencer #(
    .NUM_STATES   (NS),
    .CYCLE_TIMEOUT(TO)
  ) dut (
    .clk_2M5     (clk),
    .rst_n       (rst_n),
    .mode_button (mode_button),
    .laser_tuning(laser_tuning),
    .cycle_start (cycle_start),
    .state       (state),
    .mode_change (mode_change),
    .tuning_ack  (tuning_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int exp);
    mode_button = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic wait_change(input string tag, input int bound,
                             output int c);
    int e;
    c = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      mode_button = 1'b0;
      cycle_start = 1'b0;
      if (mode_change) begin
        c = i;
        break;
      end
    end
    if (c < 0) begin
      chk({tag, "_timeout"}, int'(mode_change), 1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, int'(state), e);
    end
  endtask

  task automatic quiet(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mode_button = 1'b0;
      cycle_start = 1'b0;
      if (mode_change) pulses++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_chg", int'(mode_change), 0);
    chk("rst_ack", int'(tuning_ack), 0);
    rst_n = 1'b1;
    @(negedge clk);

    press(1);
    wait_change("adv_0_1", 10, cyc);
    chk("lat_0_1", cyc, 2);
    @(negedge clk);
    chk("one_pulse", int'(mode_change), 0);

    press(2);
    quiet(100, cnt);
    chk("pop1_hold_pulses", cnt, 0);
    chk("pop1_hold_state", int'(state), 1);
    cycle_start = 1'b1;
    wait_change("adv_1_2", 5, cyc);
    chk("lat_cs", cyc, 1);

    for (int s = 3; s <= 6; s++) begin
      press(s);
      wait_change("adv_run", 10, cyc);
      chk("lat_run", cyc, 2);
    end

    press(0);
    quiet(5, cnt);
    for (int k = 0; k < 3; k++) begin
      mode_button = 1'b1;
      quiet(1, cnt);
      quiet(2, cnt);
    end
    chk("pop6_hold_state", int'(state), 6);
    cycle_start = 1'b1;
    wait_change("wrap_6_0", 5, cyc);
    quiet(20, cnt);
    chk("wrap_single_adv", cnt, 0);
    chk("wrap_state", int'(state), 0);

    press(1);
    wait_change("adv_0_1b", 10, cyc);
    mode_button = 1'b1;
    quiet(20, cnt);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_chg", int'(mode_change), 0);
    chk("midrst_ack", int'(tuning_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(30, cnt);
    chk("postrst_pulses", cnt, 0);
    chk("postrst_state", int'(state), 0);

    press(1);
    wait_change("adv_0_1c", 10, cyc);
    press(2);
    wait_change("timeout_adv", TO + 10, cyc);
    chk("timeout_lat", int'(cyc >= TO && cyc <= TO + 2), 1);

    press(3);
    wait_change("adv_2_3", 10, cyc);

`ifdef LASER_TUNING_EN
    laser_tuning = 1'b1;
    exp_q.push_back(0);
    wait_change("tune_to0", 6, cyc);
    chk("tune_lat", int'(cyc <= 4), 1);
    chk("tune_ack_on", int'(tuning_ack), 1);
    mode_button = 1'b1;
    quiet(3, cnt);
    mode_button = 1'b1;
    quiet(10, cnt);
    chk("tune_btn_ignored", cnt, 0);
    chk("tune_state_hold", int'(state), 0);
    laser_tuning = 1'b0;
    exp_q.push_back(3);
    wait_change("tune_restore", 6, cyc);
    chk("tune_ack_off", int'(tuning_ack), 0);
    quiet(10, cnt);
    chk("tune_after_pulses", cnt, 0);
`else
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      laser_tuning = i[1];
      @(negedge clk);
      if (mode_change || tuning_ack || state != 3'd3) cnt++;
    end
    laser_tuning = 1'b0;
    chk("notune_effects", cnt, 0);
    chk("notune_state", int'(state), 3);
    chk("notune_ack", int'(tuning_ack), 0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter NUM_STATES, default 7, number of operating modes (0..NUM_STATES-1, max 8).
REQ-002 SHALL have parameter CYCLE_TIMEOUT, default 50000, clk_2M5 cycles to wait for a POP cycle boundary before forcing a change (20 ms).
REQ-003 SHALL have port clk_2M5  input  1  2.5 MHz system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port mode_button  input  1  debounced mode request, active-high level, synchronous to clk_2M5.
REQ-006 SHALL have port laser_tuning  input  1  STM32 tuning request, active-high, asynchronous.
REQ-007 SHALL have port cycle_start  input  1  one-cycle pulse from POPtimers at the start of each POP cycle.
REQ-008 SHALL have port state  output  3  current operating mode.
REQ-009 SHALL have port mode_change  output  1  one-cycle pulse in the cycle that state takes a new value.
REQ-010 SHALL have port tuning_ack  output  1  high while mode 0 is held on behalf of laser_tuning.

Function
REQ-011 SHALL detect a mode_button rising edge by comparison with its value registered one cycle earlier; a level held high SHALL produce one edge only.
REQ-012 SHALL set a single pending flag on each detected edge; edges arriving while the flag is set SHALL be discarded (no queueing).
REQ-013 SHALL use controller states RUN, WAIT, TUNE_WAIT, TUNE.
REQ-014 RUN: pending set and state not in {1,6} -> commit next = state+1 on the following edge, clear pending, pulse mode_change, stay RUN.
REQ-015 RUN: pending set and state in {1,6} -> enter WAIT, clear timeout counter to 0.
REQ-016 WAIT: counter increments once per cycle; cycle_start high or counter == CYCLE_TIMEOUT-1 -> commit state+1, pulse mode_change, clear pending, return RUN.
REQ-017 Increment SHALL wrap: state NUM_STATES-1 advances to 0; values >= NUM_STATES SHALL never appear on state.
REQ-018 cycle_start and counter expiry in the same cycle SHALL produce exactly one commit.
REQ-019 mode_change SHALL be low in every cycle in which state is unchanged, including commits to an identical value (not possible when NUM_STATES > 1).
REQ-020 Latency: button edge to state update SHALL be 2 cycles in non-POP modes; in modes 1/6 SHALL be <= CYCLE_TIMEOUT+2 cycles.

Reset
REQ-021 While rst_n is low: state = 0, mode_change = 0, tuning_ack = 0, controller = RUN, pending = 0, timeout counter = 0, saved mode = 0, synchroniser flops = 0.
REQ-022 rst_n deassertion mid-WAIT or mid-TUNE SHALL discard pending work; no mode_change pulse on the first cycle after reset.

Configuration
REQ-023 Macro LASER_TUNING_EN SHALL compile in laser-tuning override; without it laser_tuning is unused, tuning_ack is tied 0, TUNE_WAIT/TUNE are absent.
REQ-024 With LASER_TUNING_EN, laser_tuning SHALL pass through a 2-flop synchroniser; a rising edge of the synchronised signal SHALL save state, clear pending, enter TUNE_WAIT (from RUN or WAIT).
REQ-025 TUNE_WAIT SHALL apply the same boundary rule as REQ-014..016 but with target 0; on commit state = 0, mode_change pulses (if state was nonzero), tuning_ack = 1, enter TUNE.
REQ-026 TUNE: mode_button edges SHALL be ignored; synchronised laser_tuning falling -> state = saved mode, tuning_ack = 0 same cycle, mode_change pulses if saved mode != 0, enter RUN.
REQ-027 Tuning rising edge and a RUN-state commit in the same cycle: tuning SHALL win, button request discarded.
REQ-028 laser_tuning falling during TUNE_WAIT SHALL abort to RUN with state unchanged, tuning_ack never asserted.

Verification
REQ-029 Reset, state=0; pulse mode_button 1 cycle -> state=1 two cycles after edge, one mode_change pulse.
REQ-030 state=1, press button, cycle_start pulse 100 cycles later -> state=2 one cycle after cycle_start; no cycle_start -> state=2 at CYCLE_TIMEOUT (50000) cycles.
REQ-031 From state=6, press -> state=0 (wrap); three presses within WAIT -> single advance only.
REQ-032 LASER_TUNING_EN, state=3: raise laser_tuning -> state=0, tuning_ack=1 within 4 cycles; button presses ignored; drop -> state=3, tuning_ack=0.
REQ-033 Assert rst_n low during WAIT from state=1 -> state=0, all outputs 0; release, no mode_change pulse, no pending advance.
REQ-034 Without LASER_TUNING_EN, toggle laser_tuning -> state and tuning_ack unaffected (tuning_ack constant 0).
